truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles each input vector is held before f is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a 16-vector sweep.
REQ-005 SHALL have port exp, input, 16, the expected truth table; bit i is the expected f for vector i.
REQ-006 SHALL have port f_in, input, 1, the output of the downstream 4-input combinational function under test.
REQ-007 SHALL have ports x1, x2, x3, x4, output, 1 each, driving the function inputs; {x1,x2,x3,x4} equals the current vector index, with x1 as MSB.
REQ-008 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking sweep completion.
REQ-010 SHALL have port tt, output, 16, the captured truth table; bit i is f_in sampled for vector i.
REQ-011 SHALL have port ones_cnt, output, 5, the count of 1s captured in the current or last sweep (0..16).
REQ-012 SHALL have port pass, output, 1, high when tt == exp; valid from the done cycle until the next start.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, SAMPLE and DONE; all outputs registered.
REQ-014 SHALL, in IDLE, on start=1: clear tt, ones_cnt, pass, the vector index and the settle counter, and enter APPLY on the next edge.
REQ-015 SHALL, in APPLY: drive x from the index, increment the settle counter, and enter SAMPLE once the counter reaches SETTLE-1.
REQ-016 SHALL, in SAMPLE (one cycle): write f_in to tt[index] and add f_in to ones_cnt.
REQ-017 SHALL, on leaving SAMPLE with index < 15: increment the index, clear the settle counter and return to APPLY.
REQ-018 SHALL, on leaving SAMPLE with index == 15: enter DONE.
REQ-019 SHALL hold each vector for exactly SETTLE+1 cycles.
REQ-020 SHALL assert done exactly 16*(SETTLE+1) cycles after the edge that samples start (48 cycles for SETTLE=2).
REQ-021 SHALL, in DONE: assert done for one cycle, load pass = (tt_final == exp), where tt_final includes bit 15, reset the index to 0, and enter IDLE on the next edge.
REQ-022 SHALL drive busy high in APPLY and SAMPLE and low in IDLE and DONE.
REQ-023 SHALL ignore start in APPLY, SAMPLE and DONE, with no restart and no corruption of tt.
REQ-024 SHALL sample exp only in DONE, so exp may change freely during the sweep.
REQ-025 SHALL hold tt, ones_cnt and pass in IDLE after a sweep until the next accepted start.
REQ-026 SHALL keep ones_cnt 5 bits wide with no wrap, since the maximum is 16.
REQ-027 SHALL drive x to 0000 in IDLE and DONE.

Reset
REQ-028 SHALL, on rst=1 at any time and independent of clk, force: state IDLE, index 0, settle counter 0, x 0000, busy 0, done 0, tt 0x0000, ones_cnt 0, pass 0.
REQ-029 SHALL abort a sweep in progress on rst, without asserting done; after rst deasserts, the next start begins a fresh sweep from vector 0000.

Verification
REQ-030 SHALL pass this scenario: f_in = x1&x2, exp=0xF000, SETTLE=2, start pulse -> done 48 cycles later, tt=0xF000, ones_cnt=4, pass=1.
REQ-031 SHALL pass this scenario: f_in = x1^x2^x3^x4, exp=0x6996 -> tt=0x6996, ones_cnt=8, pass=1; each x vector is held exactly 3 cycles, in order 0000..1111.
REQ-032 SHALL pass this scenario: f_in tied 1, exp=0xFFFE -> tt=0xFFFF, ones_cnt=16 (no wrap), pass=0.
REQ-033 SHALL pass this scenario: start pulsed again at vectors 0101 and 1111 mid-sweep -> ignored; done still at cycle 48, tt correct.
REQ-034 SHALL pass this scenario: rst asserted between clock edges during vector 0111 -> immediately busy=0, tt=0, x=0000, no done; a new start then yields a full correct sweep.
REQ-035 SHALL pass this scenario: SETTLE=1 with f_in = x4 -> done 32 cycles after start, tt=0xAAAA, ones_cnt=8.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Purpose: steps a 4-input combinational function under test through all
// 16 input vectors (0000..1111, x1 = MSB), holds each vector SETTLE+1
// cycles, samples the function output in the last of those cycles and
// assembles the observed truth table. On completion it pulses done and
// reports whether the captured table matches the expected one.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - one-cycle request to begin a sweep (honoured only when idle)
//   exp[15:0] - expected truth table, bit i = expected f for vector i
//   f_in      - output of the function under test
//   x1..x4    - function inputs, {x1,x2,x3,x4} = current vector index
//   busy      - high while a sweep is in progress
//   done      - one-cycle pulse when a sweep completes
//   tt[15:0]  - captured truth table, bit i = f_in sampled for vector i
//   ones_cnt  - number of 1s captured (0..16)
//   pass      - tt == exp, valid from the done cycle until the next start
module truth_table_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] exp,
    input  logic        f_in,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  ones_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    // APPLY lasts SETTLE cycles (counter 0..SETTLE-1), SAMPLE one more,
    // giving SETTLE+1 cycles per vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] index;
    logic [3:0] settle_cnt;
    logic [3:0] x_vec;
    logic [15:0] tt_final;

    assign {x1, x2, x3, x4} = x_vec;

    // The comparison that loads pass is made on the edge that also writes
    // bit 15, so the final bit is merged in here rather than read from tt.
    assign tt_final = {f_in, tt[14:0]};

    // Single sequential FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            index      <= 4'd0;
            settle_cnt <= 4'd0;
            x_vec      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt         <= 16'h0000;
            ones_cnt   <= 5'd0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tt         <= 16'h0000;
                        ones_cnt   <= 5'd0;
                        pass       <= 1'b0;
                        index      <= 4'd0;
                        settle_cnt <= 4'd0;
                        x_vec      <= 4'd0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end

                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SAMPLE: begin
                    tt[index] <= f_in;
                    ones_cnt  <= ones_cnt + {4'd0, f_in};
                    if (index == 4'd15) begin
                        // exp is only looked at here, so it may change
                        // freely while the sweep runs.
                        pass  <= (tt_final == exp);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        index <= 4'd0;
                        x_vec <= 4'd0;
                        state <= DONE;
                    end else begin
                        index      <= index + 4'd1;
                        x_vec      <= index + 4'd1;
                        settle_cnt <= 4'd0;
                        state      <= APPLY;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
//
// Purpose: self-checking bench for truth_table_sweeper. Two instances are
// used, one with SETTLE=2 and one with SETTLE=1, each driven by a bench
// model of the function under test. Expected results are pushed to a
// scoreboard when a sweep is launched and popped when done is observed.
//
// Ports: none (top-level bench).
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start2 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] exp_v = 16'h0000;
    int          mode2 = 0;
    int          mode1 = 0;

    logic        d2_x1, d2_x2, d2_x3, d2_x4, d2_busy, d2_done, d2_pass, f2;
    logic [15:0] d2_tt;
    logic [4:0]  d2_ones;
    logic        d1_x1, d1_x2, d1_x3, d1_x4, d1_busy, d1_done, d1_pass, f1;
    logic [15:0] d1_tt;
    logic [4:0]  d1_ones;
    logic [3:0]  x2v, x1v;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        pass;
        int          done_at;
    } expect_t;

    expect_t sb[$];

    always #5 clk = ~clk;

    // Functions under test: 0 = x1&x2, 1 = parity, 2 = constant 1, 3 = x4.
    function automatic logic f_model(input int mode, input logic [3:0] v);
        case (mode)
            0:       return v[3] & v[2];
            1:       return ^v;
            2:       return 1'b1;
            default: return v[0];
        endcase
    endfunction

    function automatic expect_t build_expect(input int mode, input logic [15:0] exp_final,
                                             input int per);
        expect_t e;
        logic [3:0] v;
        e.tt   = 16'h0000;
        e.ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            e.tt[i] = f_model(mode, v);
            e.ones  = e.ones + {4'd0, e.tt[i]};
        end
        e.pass    = (e.tt == exp_final);
        e.done_at = 16 * per;
        return e;
    endfunction

    assign x2v = {d2_x1, d2_x2, d2_x3, d2_x4};
    assign x1v = {d1_x1, d1_x2, d1_x3, d1_x4};
    assign f2  = f_model(mode2, x2v);
    assign f1  = f_model(mode1, x1v);

    truth_table_sweeper #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .exp(exp_v), .f_in(f2),
        .x1(d2_x1), .x2(d2_x2), .x3(d2_x3), .x4(d2_x4),
        .busy(d2_busy), .done(d2_done), .tt(d2_tt), .ones_cnt(d2_ones), .pass(d2_pass)
    );

    truth_table_sweeper #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .exp(exp_v), .f_in(f1),
        .x1(d1_x1), .x2(d1_x2), .x3(d1_x3), .x4(d1_x4),
        .busy(d1_busy), .done(d1_done), .tt(d1_tt), .ones_cnt(d1_ones), .pass(d1_pass)
    );

    // Launches a sweep on the selected instance and follows it cycle by
    // cycle: the vector order and hold time are tallied into seq_err, the
    // cycle of the done pulse is returned in done_at (-1 if it never came).
    // exp is held at a wrong value until vector 14 so that only its final
    // value can produce the right pass.
    task automatic drive_sweep(input int sel, input logic [15:0] exp_final, input bit restarts,
                               output int done_at, output int seq_err,
                               output logic [15:0] o_tt, output logic [4:0] o_ones,
                               output logic o_pass);
        int per = (sel == 2) ? 3 : 2;
        int n = 0;
        bit r5 = 0, r15 = 0;
        logic [3:0] cx;
        logic cb, cd;
        done_at = -1;
        seq_err = 0;
        o_tt = 16'h0000;
        o_ones = 5'd0;
        o_pass = 1'b0;
        exp_v = ~exp_final;
        @(negedge clk);
        if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        start1 = 1'b0;
        while (done_at < 0 && n <= 200) begin
            cx = (sel == 2) ? x2v : x1v;
            cb = (sel == 2) ? d2_busy : d1_busy;
            cd = (sel == 2) ? d2_done : d1_done;
            if (cd) begin
                done_at = n;
                o_tt   = (sel == 2) ? d2_tt : d1_tt;
                o_ones = (sel == 2) ? d2_ones : d1_ones;
                o_pass = (sel == 2) ? d2_pass : d1_pass;
                if (cb || cx != 4'd0) seq_err++;
                if (restarts) begin
                    if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
                end
            end else if (n < 16 * per) begin
                if (cx != 4'(n / per) || !cb) seq_err++;
            end
            if (cx == 4'd14) exp_v = exp_final;
            if (restarts && !cd && cx == 4'd5 && !r5) begin
                r5 = 1;
                if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
            end
            if (restarts && !cd && cx == 4'd15 && !r15) begin
                r15 = 1;
                if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
            end
            @(posedge clk); #1;
            start2 = 1'b0;
            start1 = 1'b0;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_checks++;
        if ({x2v, d2_busy, d2_done, d2_pass} !== 7'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl2: got %b required 0000000", {x2v, d2_busy, d2_done, d2_pass});
        end
        n_checks++;
        if ({d2_tt, d2_ones} !== 21'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data2: got tt=%h ones=%0d required 0", d2_tt, d2_ones);
        end
        n_checks++;
        if ({x1v, d1_busy, d1_done, d1_pass, d1_tt, d1_ones} !== 28'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_all1: got x=%b busy=%b tt=%h ones=%0d required 0",
                     x1v, d1_busy, d1_tt, d1_ones);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one sweep on the given instance and checks every result field
    // against the scoreboard entry pushed at launch.
    task automatic test_sweep(input string name, input int sel, input int mode,
                              input logic [15:0] exp_final, input bit restarts);
        expect_t e;
        int done_at, seq_err;
        logic [15:0] o_tt;
        logic [4:0] o_ones;
        logic o_pass;
        if (sel == 2) mode2 = mode; else mode1 = mode;
        sb.push_back(build_expect(mode, exp_final, (sel == 2) ? 3 : 2));
        drive_sweep(sel, exp_final, restarts, done_at, seq_err, o_tt, o_ones, o_pass);
        e = sb.pop_front();
        n_checks++;
        if (done_at !== e.done_at) begin
            n_fail++;
            $display("[TB] FAIL %s_done_cycle: got %0d required %0d", name, done_at, e.done_at);
        end
        n_checks++;
        if (seq_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL %s_sequence: got %0d bad cycles required 0", name, seq_err);
        end
        n_checks++;
        if (o_tt !== e.tt) begin
            n_fail++;
            $display("[TB] FAIL %s_tt: got %h required %h", name, o_tt, e.tt);
        end
        n_checks++;
        if (o_ones !== e.ones) begin
            n_fail++;
            $display("[TB] FAIL %s_ones: got %0d required %0d", name, o_ones, e.ones);
        end
        n_checks++;
        if (o_pass !== e.pass) begin
            n_fail++;
            $display("[TB] FAIL %s_pass: got %b required %b", name, o_pass, e.pass);
        end
    endtask

    task automatic test_and;
        test_sweep("and", 2, 0, 16'hF000, 1'b0);
    endtask

    task automatic test_xor;
        test_sweep("xor", 2, 1, 16'h6996, 1'b0);
    endtask

    task automatic test_all_ones_hold;
        test_sweep("ones", 2, 2, 16'hFFFE, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({d2_tt, d2_ones, d2_pass, d2_busy, d2_done} !== {16'hFFFF, 5'd16, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL idle_hold: got tt=%h ones=%0d pass=%b busy=%b done=%b required FFFF 16 0 0 0",
                     d2_tt, d2_ones, d2_pass, d2_busy, d2_done);
        end
    endtask

    task automatic test_restart_ignored;
        test_sweep("restart", 2, 0, 16'hF000, 1'b1);
        n_checks++;
        if (d2_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL restart_after_done: got busy=%b required 0", d2_busy);
        end
    endtask

    task automatic test_async_reset;
        int k = 0;
        int done_seen = 0;
        mode2 = 1;
        exp_v = 16'h6996;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        while (x2v != 4'd7 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("[TB] FAIL areset_reach7: got x=%b required 0111 within 100 cycles", x2v);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({d2_busy, d2_done, x2v, d2_tt, d2_ones} !== 27'd0) begin
            n_fail++;
            $display("[TB] FAIL areset_clear: got busy=%b done=%b x=%b tt=%h ones=%0d required 0",
                     d2_busy, d2_done, x2v, d2_tt, d2_ones);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) begin
            @(posedge clk); #1;
            if (d2_done || d2_busy) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL areset_no_done: got %0d active cycles required 0", done_seen);
        end
        test_sweep("after_rst", 2, 1, 16'h6996, 1'b0);
    endtask

    task automatic test_settle1;
        test_sweep("settle1", 1, 3, 16'hAAAA, 1'b0);
    endtask

    initial begin
        test_reset;
        test_and;
        test_xor;
        test_all_ones_hold;
        test_restart_ignored;
        test_async_reset;
        test_settle1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
